// File: rtl/servive_pll_reset_ctrl.sv
// Purpose: drives the PLL asynchronous reset, supervises lock with timeout/retry,
//          and releases a downstream reset once lock has been stable long enough.
// Latency: outputs registered from next state; i_locked reaches the FSM after 2 sync flops.
// Backpressure: none; i_req is a single-cycle strobe that pre-empts every transition.
//
// Ports:
//   i_clk         board reference clock (the only clock)
//   i_rst_n       asynchronous active-low reset
//   i_locked      PLL lock, asynchronous, synchronized internally
//   i_req         single-cycle re-lock request
//   o_pll_areset  active-high PLL reset (ARESET and FAIL)
//   o_rst         active-high downstream reset (all states except RUN)
//   o_ready       high in RUN
//   o_fail        high in FAIL
//   o_retry_cnt   lock timeouts since the last fresh ARESET entry
//
// Build option: define SERVIVE_PLL_AUTO_RELOCK_EN to re-pulse the PLL reset on
// lock loss in RUN; otherwise lock loss in RUN falls back to WAIT_LOCK.

module servive_pll_reset_ctrl #(
  parameter int ARESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int LOCK_STABLE   = 1024,
  parameter int MAX_RETRY     = 7
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_locked,
  input  logic       i_req,
  output logic       o_pll_areset,
  output logic       o_rst,
  output logic       o_ready,
  output logic       o_fail,
  output logic [2:0] o_retry_cnt
);

  // Counter is sized from the largest parameter so every terminal count fits.
  localparam int MAX_AB  = (ARESET_CYCLES > LOCK_TIMEOUT) ? ARESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_ABC = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
  localparam int MAX_P   = (MAX_ABC > MAX_RETRY) ? MAX_ABC : MAX_RETRY;
  localparam int CW      = $clog2(MAX_P) + 1;

  // The counter clears on state entry, so "N cycles in a state" ends when it reads N-1.
  localparam logic [CW-1:0] C_ARESET_LAST  = CW'(ARESET_CYCLES - 1);
  localparam logic [CW-1:0] C_TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] C_STABLE_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [2:0]    C_MAX_RETRY    = 3'(MAX_RETRY);

  localparam logic [2:0] S_ARESET    = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABILIZE = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAIL      = 3'd4;

  logic          r_sync1;
  logic          r_lk;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_retry;
  logic          r_pll_areset;
  logic          r_rst;
  logic          r_ready;
  logic          r_fail;

  logic [2:0]    w_nxt_state;
  logic [CW-1:0] w_nxt_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic [2:0]    w_nxt_retry;
  logic [2:0]    w_retry_inc;

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_lk    <= 1'b0;
    end else begin
      r_sync1 <= i_locked;
      r_lk    <= r_sync1;
    end
  end

  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_retry_inc = r_retry + 3'd1;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_retry = r_retry;
    if (i_req) begin
      // A request restarts the reset pulse from scratch, even when already in ARESET.
      w_nxt_state = S_ARESET;
      w_nxt_cnt   = '0;
      w_nxt_retry = 3'd0;
    end else begin
      case (r_state)
        S_ARESET: begin
          if (r_cnt == C_ARESET_LAST) w_nxt_state = S_WAIT_LOCK;
          else                        w_nxt_cnt   = w_cnt_inc;
        end
        S_WAIT_LOCK: begin
          // Lock is tested first so a lock arriving on the timeout cycle wins.
          if (r_lk) begin
            w_nxt_state = S_STABILIZE;
          end else if (r_cnt == C_TIMEOUT_LAST) begin
            w_nxt_retry = w_retry_inc;
            w_nxt_state = (w_retry_inc == C_MAX_RETRY) ? S_FAIL : S_ARESET;
          end else begin
            w_nxt_cnt = w_cnt_inc;
          end
        end
        S_STABILIZE: begin
          if (!r_lk) begin
            w_nxt_state = S_WAIT_LOCK;
          end else if (r_cnt == C_STABLE_LAST) begin
            w_nxt_state = S_RUN;
            w_nxt_retry = 3'd0;
          end else begin
            w_nxt_cnt = w_cnt_inc;
          end
        end
        S_RUN: begin
          if (!r_lk) begin
`ifdef SERVIVE_PLL_AUTO_RELOCK_EN
            w_nxt_state = S_ARESET;
            w_nxt_retry = 3'd0;
`else
            w_nxt_state = S_WAIT_LOCK;
`endif
          end
        end
        S_FAIL: begin
          w_nxt_state = S_FAIL;
        end
        default: begin
          w_nxt_state = S_ARESET;
          w_nxt_retry = 3'd0;
        end
      endcase
      if (w_nxt_state != r_state) w_nxt_cnt = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_ARESET;
      r_cnt   <= '0;
      r_retry <= 3'd0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_retry <= w_nxt_retry;
    end
  end

  // Outputs decode the next state so they switch on the same edge as the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pll_areset <= 1'b1;
      r_rst        <= 1'b1;
      r_ready      <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_pll_areset <= (w_nxt_state == S_ARESET) || (w_nxt_state == S_FAIL);
      r_rst        <= (w_nxt_state != S_RUN);
      r_ready      <= (w_nxt_state == S_RUN);
      r_fail       <= (w_nxt_state == S_FAIL);
    end
  end

  assign o_pll_areset = r_pll_areset;
  assign o_rst        = r_rst;
  assign o_ready      = r_ready;
  assign o_fail       = r_fail;
  assign o_retry_cnt  = r_retry;

endmodule

// File: tb/tb_servive_pll_reset_ctrl.sv
// Purpose: checks PLL reset controller bring-up, retry/FAIL, glitches, lock loss and resets.
// Latency: expected output-change events are predicted with edge numbers from timing rules.
// Backpressure: none; a negedge monitor pops one expectation per observed output change.

module tb_servive_pll_reset_ctrl;

  localparam int P_ARESET  = 4;
  localparam int P_TIMEOUT = 32;
  localparam int P_STABLE  = 8;
  localparam int P_RETRY   = 2;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_locked;
  logic       i_req;
  logic       o_pll_areset;
  logic       o_rst;
  logic       o_ready;
  logic       o_fail;
  logic [2:0] o_retry_cnt;

  servive_pll_reset_ctrl #(
    .ARESET_CYCLES(P_ARESET),
    .LOCK_TIMEOUT (P_TIMEOUT),
    .LOCK_STABLE  (P_STABLE),
    .MAX_RETRY    (P_RETRY)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_locked    (i_locked),
    .i_req       (i_req),
    .o_pll_areset(o_pll_areset),
    .o_rst       (o_rst),
    .o_ready     (o_ready),
    .o_fail      (o_fail),
    .o_retry_cnt (o_retry_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int edge_n = 0;
  always @(posedge i_clk) edge_n <= edge_n + 1;

  int errors = 0;
  int checks = 0;

  // Output vector layout: {pll_areset, rst, ready, fail, retry_cnt[2:0]}
  function automatic logic [6:0] mk(input logic a, input logic r, input logic rd,
                                    input logic f, input logic [2:0] rc);
    return {a, r, rd, f, rc};
  endfunction

  logic [6:0] RSTV, WAITV, RUNV;
  initial begin
    RSTV  = mk(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    WAITV = mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    RUNV  = mk(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
  end

  int         exp_e[$];
  logic [6:0] exp_v[$];
  int         exp_id[$];
  int         next_id = 0;

  task automatic push(input int e, input logic [6:0] v);
    exp_e.push_back(e);
    exp_v.push_back(v);
    exp_id.push_back(next_id);
    next_id++;
  endtask

  // Monitor: every change of the output vector must match the next prediction.
  logic       mon_en = 1'b0;
  logic [6:0] mon_v;
  logic [6:0] mon_prev;
  int         pe;
  logic [6:0] pv;
  int         pid;
  always @(negedge i_clk) begin
    if (mon_en) begin
      mon_v = {o_pll_areset, o_rst, o_ready, o_fail, o_retry_cnt};
      if (mon_v !== mon_prev) begin
        checks++;
        if (exp_e.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change edge=%0d got=%b required=no change", edge_n, mon_v);
        end else begin
          pe  = exp_e.pop_front();
          pv  = exp_v.pop_front();
          pid = exp_id.pop_front();
          if (edge_n != pe || mon_v !== pv) begin
            errors++;
            $display("FAIL evt%0d got edge=%0d out=%b required edge=%0d out=%b",
                     pid, edge_n, mon_v, pe, pv);
          end
        end
      end
      mon_prev = mon_v;
    end
  end

  // Returns #1 after posedge number n (immediately if already past it).
  task automatic at_edge(input int n);
    while (edge_n < n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Raise lock d edges after WAIT_LOCK entry at w; optional one-cycle glitch g_off
  // edges after STABILIZE entry. Lock is seen 3 edges after it is driven.
  task automatic relock(input int w, input int d, input int g_off, output int run);
    int e;
    int s;
    int g;
    e = w + d;
    at_edge(e);
    i_locked = 1'b1;
    s = e + 3;
    if (g_off >= 0) begin
      g = s + g_off;
      // Glitch drops STABILIZE back to WAIT_LOCK at g+3; steady lock re-enters at g+4.
      run = g + 4 + P_STABLE;
      push(run, RUNV);
      at_edge(g);
      i_locked = 1'b0;
      at_edge(g + 1);
      i_locked = 1'b1;
    end else begin
      run = s + P_STABLE;
      push(run, RUNV);
    end
  endtask

  task automatic lose_lock(input int run, output int w);
    int e;
    at_edge(run + int'($urandom_range(1, 6)));
    e = edge_n;
    i_locked = 1'b0;
`ifdef SERVIVE_PLL_AUTO_RELOCK_EN
    push(e + 3, RSTV);
    push(e + 3 + P_ARESET, WAITV);
    w = e + 3 + P_ARESET;
`else
    push(e + 3, WAITV);
    w = e + 3;
`endif
  endtask

  // Lock kept low through one full timeout from WAIT_LOCK entry at w.
  task automatic timeout_once(inout int w);
    push(w + P_TIMEOUT, mk(1'b1, 1'b1, 1'b0, 1'b0, 3'd1));
    push(w + P_TIMEOUT + P_ARESET, mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd1));
    w = w + P_TIMEOUT + P_ARESET;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog edge=%0d required=bench completion", edge_n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    int w;
    int run;
    int e;
    int d;
    int g;
    i_rst_n  = 1'b1;
    i_locked = 1'b0;
    i_req    = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_pll_areset, o_rst, o_ready, o_fail, o_retry_cnt} !== RSTV) begin
      errors++;
      $display("FAIL reset_values got=%b required=%b",
               {o_pll_areset, o_rst, o_ready, o_fail, o_retry_cnt}, RSTV);
    end
    mon_prev = RSTV;
    mon_en   = 1'b1;

    // Normal bring-up: lock raised 10 cycles after the areset pulse ends.
    at_edge(3);
    r = edge_n;
    push(r + P_ARESET, WAITV);
    i_rst_n = 1'b1;
    relock(r + P_ARESET, 10, -1, run);

    // Glitch in STABILIZE after 5 locked cycles.
    lose_lock(run, w);
    relock(w, int'($urandom_range(0, P_TIMEOUT - 3)), 3, run);

    // Randomized lock-loss rounds; the first one locks on the timeout cycle itself.
    for (int k = 0; k < 6; k++) begin
      lose_lock(run, w);
      if ($urandom_range(0, 2) == 0) timeout_once(w);
      d = (k == 0) ? (P_TIMEOUT - 3) : int'($urandom_range(0, P_TIMEOUT - 3));
      g = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4)) : -1;
      relock(w, d, g, run);
    end

    // Request from RUN with lock gone, a second request mid-ARESET, then retries to FAIL.
    at_edge(run + 2);
    e = edge_n;
    push(e + 1, RSTV);
    i_req    = 1'b1;
    i_locked = 1'b0;
    at_edge(e + 1);
    i_req = 1'b0;
    at_edge(e + 2);
    push(e + 3 + P_ARESET, WAITV);
    i_req = 1'b1;
    at_edge(e + 3);
    i_req = 1'b0;
    w = e + 3 + P_ARESET;
    push(w + P_TIMEOUT, mk(1'b1, 1'b1, 1'b0, 1'b0, 3'd1));
    push(w + P_TIMEOUT + P_ARESET, mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd1));
    push(w + 2 * P_TIMEOUT + P_ARESET, mk(1'b1, 1'b1, 1'b0, 1'b1, 3'd2));
    at_edge(w + 2 * P_TIMEOUT + P_ARESET + 12);

    // Request out of FAIL, then a normal bring-up.
    e = edge_n;
    push(e + 1, RSTV);
    i_req = 1'b1;
    at_edge(e + 1);
    i_req = 1'b0;
    w = e + 1 + P_ARESET;
    push(w, WAITV);
    relock(w, int'($urandom_range(0, P_TIMEOUT - 3)), -1, run);

    // Asynchronous reset in RUN, released with lock still present.
    at_edge(run + 3);
    #1;
    push(edge_n, RSTV);
    i_rst_n = 1'b0;
    at_edge(edge_n + 3);
    r = edge_n;
    push(r + P_ARESET, WAITV);
    // Lock already synchronized by WAIT_LOCK entry, so STABILIZE begins one edge later.
    push(r + P_ARESET + 1 + P_STABLE, RUNV);
    i_rst_n = 1'b1;
    run = r + P_ARESET + 1 + P_STABLE;

    lose_lock(run, w);
    relock(w, int'($urandom_range(0, P_TIMEOUT - 3)), -1, run);

    at_edge(run + 10);
    while (exp_e.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL missing_evt%0d got=no change required edge=%0d out=%b",
               exp_id[0], exp_e[0], exp_v[0]);
      void'(exp_e.pop_front());
      void'(exp_v.pop_front());
      void'(exp_id.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/servive_pll_reset_ctrl.md
# servive_pll_reset_ctrl

Controller that drives the PLL's asynchronous reset and supervises its lock indication. It runs on the board input clock (ahead of the PLL) and pulses the PLL reset for a minimum width. It waits for lock with a timeout and retries a bounded number of times. It releases a downstream reset only after lock has been stable for a programmable interval. It sits between the board clock/reset pins and the PLL clock generator, and replaces the raw pin reset on the PLL `areset` input.

## Interface
Parameters:
- `ARESET_CYCLES`, 16: PLL reset pulse width in `i_clk` cycles (≥1).
- `LOCK_TIMEOUT`, 65535: cycles allowed in WAIT_LOCK before a retry (≥1).
- `LOCK_STABLE`, 1024: consecutive synchronized-locked cycles required before release (≥1).
- `MAX_RETRY`, 7: lock timeouts tolerated before FAIL (1–7).

Ports:
- `i_clk`  in  1: board reference clock; the only clock.
- `i_rst_n`  in  1: asynchronous, active-low reset.
- `i_locked`  in  1: PLL lock; asynchronous to `i_clk`; synchronized internally.
- `i_req`  in  1: single-cycle re-lock request, synchronous to `i_clk`.
- `o_pll_areset`  out  1: active-high reset to the PLL.
- `o_rst`  out  1: active-high reset for downstream logic.
- `o_ready`  out  1: high only in RUN.
- `o_fail`  out  1: high only in FAIL.
- `o_retry_cnt`  out  3: number of timeouts since the last ARESET entry from reset, `i_req` or RUN.

## Operation
- **Lock synchronizer:** `i_locked` passes through a 2-FF synchronizer. All decisions use the synchronized value `lk`.
- **Cycle counter:** one shared counter, width `$clog2` of the largest parameter plus 1. It clears on every state change.

States and transitions:
- **ARESET:** `o_pll_areset`=1.
  - After `ARESET_CYCLES` cycles → WAIT_LOCK.
- **WAIT_LOCK:** `o_pll_areset`=0.
  - `lk`=1 → STABILIZE.
  - Counter reaches `LOCK_TIMEOUT` with `lk`=0 → increment `o_retry_cnt`. If the new value equals `MAX_RETRY` → FAIL, otherwise → ARESET (the count is retained).
  - A timeout and `lk`=1 in the same cycle: lock wins.
- **STABILIZE:**
  - `lk`=0 → WAIT_LOCK, with the timeout restarted.
  - `LOCK_STABLE` consecutive cycles with `lk`=1 → RUN, and `o_retry_cnt` clears.
- **RUN:** `o_rst`=0, `o_ready`=1.
  - `lk`=0 → behaviour set by the macro under Configuration.
- **FAIL:** `o_pll_areset`=1, `o_fail`=1.
  - Leaves only on `i_req` or reset.

Request handling:
- `i_req` in any state other than ARESET → ARESET, with `o_retry_cnt` cleared.
- `i_req` in ARESET: the counter restarts and the state stays ARESET.
- `i_req` has priority over every other transition in the same cycle.

Other rules:
- `o_rst`=1 in every state except RUN.
- `o_pll_areset`=1 in ARESET and FAIL only.

## Timing
- **Reset values** (while `i_rst_n`=0): state ARESET, counter 0, `o_pll_areset`=1, `o_rst`=1, `o_ready`=0, `o_fail`=0, `o_retry_cnt`=0, synchronizer flops 0.
- **Release after reset:** the ARESET count starts on the first `i_clk` edge after `i_rst_n` deasserts.
- **Registered outputs:** all outputs are decoded from the next state, so they change on the same edge as the state. No output has combinational paths from inputs.
- **Lock latency:** a rise of `i_locked` is first seen by the FSM 2 edges later. It enters STABILIZE on the 3rd edge.
- **RUN release:** `o_rst` falls exactly `LOCK_STABLE` edges after STABILIZE entry.
- **ARESET width:** `o_pll_areset` is high for exactly `ARESET_CYCLES` edges per ARESET visit.
- **Lock loss in RUN:** `o_rst` rises on the edge on which `lk`=0 is first sampled, which is 3 edges after `i_locked` falls.
- **Reset mid-operation:** `i_rst_n` low asynchronously forces the reset values in every state.

## Configuration
- **`SERVIVE_PLL_AUTO_RELOCK_EN` defined:** RUN with `lk`=0 → ARESET, with `o_retry_cnt` cleared. The PLL is actively re-reset.
- **`SERVIVE_PLL_AUTO_RELOCK_EN` undefined:** RUN with `lk`=0 → WAIT_LOCK. No PLL reset pulse is issued, and the timeout/retry rules apply from there.
- **Either case:** on entering the new state, `o_rst`=1 and `o_ready`=0.

## Test plan
Bench parameters: `ARESET_CYCLES`=4, `LOCK_TIMEOUT`=32, `LOCK_STABLE`=8, `MAX_RETRY`=2.
- **Normal bring-up:** release reset; raise `i_locked` 10 cycles after `o_pll_areset` falls → `o_pll_areset` high 4 cycles; STABILIZE 3 edges after the `i_locked` rise; `o_rst` falls 8 edges later; `o_ready`=1; `o_retry_cnt`=0.
- **Retry then FAIL:** hold `i_locked`=0 → two 4-cycle areset pulses 32 cycles apart; `o_retry_cnt` goes 1 then 2; `o_fail`=1; `o_pll_areset` held high.
- **Stabilize glitch:** drop `i_locked` for 1 cycle after 5 locked cycles in STABILIZE → back to WAIT_LOCK; `o_rst` stays 1; after a steady lock, release occurs 8 edges after re-entering STABILIZE.
- **Lock loss in RUN:** drop `i_locked` → `o_rst`=1 3 edges later. With `SERVIVE_PLL_AUTO_RELOCK_EN`: a 4-cycle areset pulse. Without it: no pulse, and re-lock proceeds via WAIT_LOCK.
- **Request from FAIL:** pulse `i_req` → ARESET on the next edge; `o_fail`=0; `o_retry_cnt`=0; then normal bring-up completes.
- **Async reset in RUN:** pull `i_rst_n` low mid-cycle → all outputs return to their reset values immediately, before the next edge.
